// File: rtl/swc_pkg.sv
// swc_pkg: shared types, pointer field positions and helpers for the
// egress scheduler slice.
package swc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BEAT  = 2'd2
    } sched_state_e;

    // Queue pointer layout (16 bits per port)
    localparam int PTR_W     = 16;
    localparam int LAST_BIT  = 15;
    localparam int FIRST_BIT = 14;
    localparam int ADDR_MSB  = 9;
    localparam int CELL_W    = ADDR_MSB + 1;

    // Cell geometry
    localparam int          BEATS_PER_CELL = 4;
    localparam logic [1:0]  LAST_BEAT      = 2'(BEATS_PER_CELL - 1);

    // One-hot grant to port index; non one-hot codes map to port 0
    function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // WRR credit load value: a zero weight still earns one grant per window
    function automatic logic [3:0] wrr_load(input logic [3:0] weight);
        return (weight == 4'd0) ? 4'd1 : weight;
    endfunction

endpackage

// File: rtl/swc_egress_sched_if.sv
// swc_egress_sched_if: bundle of the scheduler's queue, SRAM, output FIFO,
// multicast-count and free-queue signals. master = scheduler side.
interface swc_egress_sched_if;

    logic [3:0]  ptr_rdy;
    logic [63:0] ptr_dout;
    logic [3:0]  ptr_ack;
    logic [3:0]  o_cell_bp;
    logic [15:0] cfg_weight;
    logic        sram_rd_en;
    logic [11:0] sram_rd_addr;
    logic [3:0]  o_cell_fifo_wr;
    logic        o_cell_first;
    logic        o_cell_last;
    logic [9:0]  mc_addr;
    logic [3:0]  mc_rd_data;
    logic        mc_wr_en;
    logic [3:0]  mc_wr_data;
    logic        fq_wr;
    logic [9:0]  fq_din;
    logic        sched_err;

    modport master (
        input  ptr_rdy, ptr_dout, o_cell_bp, cfg_weight, mc_rd_data,
        output ptr_ack, sram_rd_en, sram_rd_addr, o_cell_fifo_wr,
               o_cell_first, o_cell_last, mc_addr, mc_wr_en, mc_wr_data,
               fq_wr, fq_din, sched_err
    );

    modport slave (
        output ptr_rdy, ptr_dout, o_cell_bp, cfg_weight, mc_rd_data,
        input  ptr_ack, sram_rd_en, sram_rd_addr, o_cell_fifo_wr,
               o_cell_first, o_cell_last, mc_addr, mc_wr_en, mc_wr_data,
               fq_wr, fq_din, sched_err
    );

endinterface

// File: rtl/swc_rr_arb.sv
// swc_rr_arb: 4-way rotating-priority picker. The grant is combinational
// from req and the registered pointer; the pointer moves to winner+1 when
// adv is asserted.
module swc_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       adv,
    output logic [3:0] grant
);

    logic [1:0] ptr_r;
    logic [1:0] idx_s;
    logic [1:0] win_idx_s;
    logic       found_s;

    // Pick the first requester at or after the pointer, wrapping around
    always_comb begin
        grant     = 4'b0000;
        idx_s     = 2'd0;
        win_idx_s = 2'd0;
        found_s   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr_r + 2'(i);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                win_idx_s    = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Advance the priority pointer past the winner on an accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else if (adv && found_s) begin
            ptr_r <= win_idx_s + 2'd1;
        end
    end

endmodule

// File: rtl/swc_egress_sched.sv
// swc_egress_sched: egress scheduler for the shared cell SRAM.
// Arbitrates the output queues, acks the winning pointer, reads the 4-beat
// cell, steers read data to the output FIFO, and handles multicast count
// write-back and pointer release.
// Optional weighted round robin: define SWC_SCHED_WRR_EN.
module swc_egress_sched
    import swc_pkg::*;
#(
    parameter int NPORT  = 4,
    parameter int RD_LAT = 1,
    parameter int MC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    swc_egress_sched_if.master  bus
);

    localparam logic [1:0] MC_BEAT = 2'(MC_LAT);

    sched_state_e       state_r;
    logic [1:0]         beat_r;
    logic [CELL_W-1:0]  cell_r;
    logic               first_r;
    logic               last_r;
    logic [NPORT-1:0]   port_oh_r;

    logic [NPORT-1:0]   ptr_ack_r;
    logic               sram_rd_en_r;
    logic [11:0]        sram_rd_addr_r;
    logic [CELL_W-1:0]  mc_addr_r;
    logic               mc_wr_en_r;
    logic [3:0]         mc_wr_data_r;
    logic               fq_wr_r;
    logic [CELL_W-1:0]  fq_din_r;
    logic               sched_err_r;

    logic [NPORT-1:0]   base_elig_s;
    logic [NPORT-1:0]   elig_s;
    logic [NPORT-1:0]   grant_s;
    logic               any_elig_s;
    logic               arb_adv_s;
    logic [1:0]         win_idx_s;
    logic [PTR_W-1:0]   win_ptr_s;
    logic               unused_ptr_s;

    assign base_elig_s  = bus.ptr_rdy & ~bus.o_cell_bp;
    assign any_elig_s   = |elig_s;
    assign arb_adv_s    = (state_r == GRANT) && any_elig_s;
    assign win_idx_s    = oh_to_idx(grant_s);
    assign win_ptr_s    = bus.ptr_dout[{win_idx_s, 4'b0000} +: PTR_W];
    assign unused_ptr_s = ^win_ptr_s[FIRST_BIT-1:CELL_W];

`ifdef SWC_SCHED_WRR_EN
    logic [NPORT-1:0][3:0] credit_r;
    logic [NPORT-1:0][3:0] credit_eff_s;
    logic [NPORT-1:0]      has_credit_s;

    // Effective credits: reload from weights when only credit blocks arbitration
    always_comb begin
        credit_eff_s = credit_r;
        has_credit_s = '0;
        elig_s       = '0;
        for (int p = 0; p < NPORT; p++) begin
            has_credit_s[p] = (credit_r[p] != 4'd0);
        end
        if (((base_elig_s & has_credit_s) == '0) && (base_elig_s != '0)) begin
            for (int p = 0; p < NPORT; p++) begin
                credit_eff_s[p] = wrr_load(bus.cfg_weight[4*p +: 4]);
            end
        end else begin
            credit_eff_s = credit_r;
        end
        for (int p = 0; p < NPORT; p++) begin
            elig_s[p] = base_elig_s[p] & (credit_eff_s[p] != 4'd0);
        end
    end

    // Commit (possibly reloaded) credits and charge the granted port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                credit_r[p] <= wrr_load(bus.cfg_weight[4*p +: 4]);
            end
        end else if (arb_adv_s) begin
            for (int p = 0; p < NPORT; p++) begin
                credit_r[p] <= credit_eff_s[p] - {3'd0, grant_s[p]};
            end
        end
    end
`else
    logic unused_cfg_s;

    assign elig_s       = base_elig_s;
    assign unused_cfg_s = ^bus.cfg_weight;
`endif

    swc_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (elig_s),
        .adv   (arb_adv_s),
        .grant (grant_s)
    );

    // Scheduler FSM: grant, beat sequencing, count write-back and release
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            beat_r         <= 2'd0;
            cell_r         <= '0;
            first_r        <= 1'b0;
            last_r         <= 1'b0;
            port_oh_r      <= '0;
            ptr_ack_r      <= '0;
            sram_rd_en_r   <= 1'b0;
            sram_rd_addr_r <= 12'd0;
            mc_addr_r      <= '0;
            mc_wr_en_r     <= 1'b0;
            mc_wr_data_r   <= 4'd0;
            fq_wr_r        <= 1'b0;
            fq_din_r       <= '0;
            sched_err_r    <= 1'b0;
        end else begin
            ptr_ack_r  <= '0;
            mc_wr_en_r <= 1'b0;
            fq_wr_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_elig_s) begin
                        state_r <= GRANT;
                    end
                end
                GRANT: begin
                    if (any_elig_s) begin
                        state_r        <= BEAT;
                        beat_r         <= 2'd0;
                        cell_r         <= win_ptr_s[ADDR_MSB:0];
                        first_r        <= win_ptr_s[FIRST_BIT];
                        last_r         <= win_ptr_s[LAST_BIT];
                        port_oh_r      <= grant_s;
                        ptr_ack_r      <= grant_s;
                        sram_rd_en_r   <= 1'b1;
                        sram_rd_addr_r <= {win_ptr_s[ADDR_MSB:0], 2'd0};
                        mc_addr_r      <= win_ptr_s[ADDR_MSB:0];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BEAT: begin
                    // Count arrives MC_LAT beats after the address; write back next cycle
                    if (beat_r == MC_BEAT) begin
                        mc_wr_en_r <= 1'b1;
                        if (bus.mc_rd_data == 4'd0) begin
                            mc_wr_data_r <= 4'd0;
                            sched_err_r  <= 1'b1;
                        end else begin
                            mc_wr_data_r <= bus.mc_rd_data - 4'd1;
                            if (bus.mc_rd_data == 4'd1) begin
                                fq_wr_r  <= 1'b1;
                                fq_din_r <= cell_r;
                            end
                        end
                    end
                    if (beat_r == LAST_BEAT) begin
                        sram_rd_en_r <= 1'b0;
                        beat_r       <= 2'd0;
                        state_r      <= any_elig_s ? GRANT : IDLE;
                    end else begin
                        beat_r         <= beat_r + 2'd1;
                        sram_rd_addr_r <= {cell_r, beat_r + 2'd1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Per-cycle write qualifiers: {port one-hot, first, last}
    logic [NPORT+1:0] qual_s;
    logic [NPORT+1:0] dly_out_s;

    assign qual_s = sram_rd_en_r ?
                    {port_oh_r, first_r && (beat_r == 2'd0), last_r && (beat_r == LAST_BEAT)} :
                    '0;

    generate
        if (RD_LAT == 0) begin : g_no_dly
            assign dly_out_s = qual_s;
        end else begin : g_dly
            logic [NPORT+1:0] dly_r [RD_LAT];

            // Delay qualifiers by the SRAM read latency; reset flushes them
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        dly_r[i] <= '0;
                    end
                end else begin
                    dly_r[0] <= qual_s;
                    for (int i = 1; i < RD_LAT; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign dly_out_s = dly_r[RD_LAT-1];
        end
    endgenerate

    assign bus.ptr_ack        = ptr_ack_r;
    assign bus.sram_rd_en     = sram_rd_en_r;
    assign bus.sram_rd_addr   = sram_rd_addr_r;
    assign bus.o_cell_fifo_wr = dly_out_s[NPORT+1:2];
    assign bus.o_cell_first   = dly_out_s[1];
    assign bus.o_cell_last    = dly_out_s[0];
    assign bus.mc_addr        = mc_addr_r;
    assign bus.mc_wr_en       = mc_wr_en_r;
    assign bus.mc_wr_data     = mc_wr_data_r;
    assign bus.fq_wr          = fq_wr_r;
    assign bus.fq_din         = fq_din_r;
    assign bus.sched_err      = sched_err_r;

endmodule

// File: tb/tb_swc_egress_sched.sv
// tb_swc_egress_sched: directed self-checking bench for swc_egress_sched.
module tb_swc_egress_sched;

    localparam int RD_LAT = 1;
    localparam int MC_LAT = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    swc_egress_sched_if bus_if ();

    swc_egress_sched #(.NPORT(4), .RD_LAT(RD_LAT), .MC_LAT(MC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int pend [4];

    logic [3:0]  ack_q  [$];
    int          ack_cyc_q [$];
    logic [11:0] addr_q [$];
    int          addr_cyc_q [$];
    logic [5:0]  wr_q   [$];
    int          wr_cyc_q [$];
    logic [9:0]  fq_q   [$];
    logic [3:0]  mcw_q  [$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic refresh_rdy();
        for (int p = 0; p < 4; p++) begin
            bus_if.ptr_rdy[p] = (pend[p] != 0);
        end
    endtask

    task automatic clear_logs();
        ack_q.delete();  ack_cyc_q.delete();
        addr_q.delete(); addr_cyc_q.delete();
        wr_q.delete();   wr_cyc_q.delete();
        fq_q.delete();   mcw_q.delete();
    endtask

    // One clock: sample outputs 1 time unit after the edge, log events, pop queues
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.ptr_ack != 4'd0) begin
            ack_q.push_back(bus_if.ptr_ack);
            ack_cyc_q.push_back(cyc);
            for (int p = 0; p < 4; p++) begin
                if (bus_if.ptr_ack[p] && pend[p] > 0) pend[p]--;
            end
        end
        refresh_rdy();
        if (bus_if.sram_rd_en) begin
            addr_q.push_back(bus_if.sram_rd_addr);
            addr_cyc_q.push_back(cyc);
        end
        if (bus_if.o_cell_fifo_wr != 4'd0) begin
            wr_q.push_back({bus_if.o_cell_first, bus_if.o_cell_last, bus_if.o_cell_fifo_wr});
            wr_cyc_q.push_back(cyc);
        end
        if (bus_if.fq_wr) fq_q.push_back(bus_if.fq_din);
        if (bus_if.mc_wr_en) mcw_q.push_back(bus_if.mc_wr_data);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < 4; p++) pend[p] = 0;
        refresh_rdy();
        bus_if.o_cell_bp = 4'd0;
        run(2);
        rst = 1'b0;
        clear_logs();
    endtask

    function automatic logic [63:0] all_outs();
        return {14'd0, bus_if.ptr_ack, bus_if.sram_rd_en, bus_if.sram_rd_addr,
                bus_if.o_cell_fifo_wr, bus_if.o_cell_first, bus_if.o_cell_last,
                bus_if.mc_addr, bus_if.mc_wr_en, bus_if.mc_wr_data, bus_if.fq_wr,
                bus_if.fq_din, bus_if.sched_err};
    endfunction

    function automatic int count_wr(input logic [3:0] oh);
        int n = 0;
        foreach (wr_q[i]) if (wr_q[i][3:0] == oh) n++;
        return n;
    endfunction

    function automatic logic [3:0] ack_at(input int i);
        return (i < ack_q.size()) ? ack_q[i] : 4'hF;
    endfunction

    function automatic logic [5:0] wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 6'h3F;
    endfunction

    function automatic logic [11:0] addr_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 12'hFFF;
    endfunction

    initial begin
        logic [23:0] pk24;
        logic [47:0] pk48;

        rst                = 1'b1;
        bus_if.ptr_rdy     = 4'd0;
        bus_if.ptr_dout    = 64'd0;
        bus_if.o_cell_bp   = 4'd0;
        bus_if.cfg_weight  = 16'h3111;
        bus_if.mc_rd_data  = 4'd1;
        for (int p = 0; p < 4; p++) pend[p] = 0;

        // Reset state
        run(2);
        check_eq("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        clear_logs();

        // Single unicast cell 0xC005 on port 0
        bus_if.ptr_dout   = {48'd0, 16'hC005};
        bus_if.mc_rd_data = 4'd1;
        pend[0] = 1;
        refresh_rdy();
        run(12);
        check_eq("uc_ack_cnt", 64'(ack_q.size()), 64'd1);
        check_eq("uc_ack", 64'(ack_at(0)), 64'h1);
        pk48 = {addr_at(0), addr_at(1), addr_at(2), addr_at(3)};
        check_eq("uc_addrs", 64'(pk48), 64'h014_015_016_017);
        check_eq("uc_wr_cnt", 64'(wr_q.size()), 64'd4);
        pk24 = {wr_at(0), wr_at(1), wr_at(2), wr_at(3)};
        check_eq("uc_wr_flags", 64'(pk24), 64'h841051);
        if (wr_cyc_q.size() > 0 && addr_cyc_q.size() > 0 && ack_cyc_q.size() > 0) begin
            check_eq("uc_rd_lat", 64'(wr_cyc_q[0] - addr_cyc_q[0]), 64'(RD_LAT));
            check_eq("uc_ack_align", 64'(addr_cyc_q[0] - ack_cyc_q[0]), 64'd0);
        end
        check_eq("uc_fq_cnt", 64'(fq_q.size()), 64'd1);
        check_eq("uc_fq_din", 64'((fq_q.size() > 0) ? fq_q[0] : 10'h3FF), 64'd5);
        check_eq("uc_mcw", 64'((mcw_q.size() > 0) ? mcw_q[0] : 4'hF), 64'd0);
        check_eq("uc_err", 64'(bus_if.sched_err), 64'd0);

        // Round-robin fairness, all four ports ready
        do_reset();
        bus_if.ptr_dout = 64'hC013_C012_C011_C010;
        for (int p = 0; p < 4; p++) pend[p] = 2;
        refresh_rdy();
        run(48);
        pk24 = {4'd0, ack_at(0), ack_at(1), ack_at(2), ack_at(3), ack_at(4)};
        check_eq("rr_order", 64'(pk24), 64'h12481);
        if (ack_cyc_q.size() >= 5) begin
            check_eq("rr_spacing", 64'(ack_cyc_q[1] - ack_cyc_q[0]), 64'd5);
            check_eq("rr_span", 64'(ack_cyc_q[4] - ack_cyc_q[0]), 64'd20);
        end
        check_eq("rr_wr_total", 64'(wr_q.size()), 64'd32);
        check_eq("rr_fq_total", 64'(fq_q.size()), 64'd8);

        // Multicast count 3 then final release with count 1
        do_reset();
        bus_if.ptr_dout   = {48'd0, 16'hC02A};
        bus_if.mc_rd_data = 4'd3;
        pend[0] = 1;
        refresh_rdy();
        run(12);
        check_eq("mc3_wr_data", 64'((mcw_q.size() > 0) ? mcw_q[0] : 4'hF), 64'd2);
        check_eq("mc3_no_fq", 64'(fq_q.size()), 64'd0);
        clear_logs();
        bus_if.mc_rd_data = 4'd1;
        pend[0] = 1;
        refresh_rdy();
        run(12);
        check_eq("mc1_wr_data", 64'((mcw_q.size() > 0) ? mcw_q[0] : 4'hF), 64'd0);
        check_eq("mc1_fq_din", 64'((fq_q.size() > 0) ? fq_q[0] : 10'h3FF), 64'h2A);

        // Backpressure raised on port 1 mid-cell
        do_reset();
        bus_if.ptr_dout = 64'h0000_C022_C021_0000;
        pend[1] = 2;
        pend[2] = 1;
        refresh_rdy();
        for (int k = 0; k < 10 && ack_q.size() == 0; k++) step();
        check_eq("bp_first_ack", 64'(ack_at(0)), 64'h2);
        step();
        bus_if.o_cell_bp = 4'b0010;
        run(20);
        check_eq("bp_p1_writes", 64'(count_wr(4'b0010)), 64'd4);
        check_eq("bp_p2_writes", 64'(count_wr(4'b0100)), 64'd4);
        check_eq("bp_acks_held", 64'(ack_q.size()), 64'd2);
        check_eq("bp_second_ack", 64'(ack_at(1)), 64'h4);
        bus_if.o_cell_bp = 4'b0000;
        run(12);
        check_eq("bp_release_ack", 64'(ack_at(2)), 64'h2);
        check_eq("bp_p1_total", 64'(count_wr(4'b0010)), 64'd8);

        // Count read as zero: error, write 0, no release
        do_reset();
        bus_if.ptr_dout   = {48'd0, 16'hC007};
        bus_if.mc_rd_data = 4'd0;
        pend[0] = 1;
        refresh_rdy();
        run(12);
        check_eq("err_flag", 64'(bus_if.sched_err), 64'd1);
        check_eq("err_no_fq", 64'(fq_q.size()), 64'd0);
        check_eq("err_mcw", 64'((mcw_q.size() > 0) ? mcw_q[0] : 4'hF), 64'd0);
        run(5);
        check_eq("err_sticky", 64'(bus_if.sched_err), 64'd1);

        // Reset asserted at beat 2 aborts the cell
        do_reset();
        bus_if.ptr_dout   = {48'd0, 16'hC009};
        bus_if.mc_rd_data = 4'd1;
        pend[0] = 1;
        refresh_rdy();
        for (int k = 0; k < 10 && ack_q.size() == 0; k++) step();
        check_eq("rst_ack_seen", 64'(ack_q.size()), 64'd1);
        run(2);
        rst = 1'b1;
        clear_logs();
        step();
        check_eq("rst_outs_zero", all_outs(), 64'd0);
        rst = 1'b0;
        run(8);
        check_eq("rst_no_wr", 64'(wr_q.size()), 64'd0);
        check_eq("rst_no_fq", 64'(fq_q.size()), 64'd0);

`ifdef SWC_SCHED_WRR_EN
        // Weighted round robin: port 3 weight 3, others 1
        bus_if.cfg_weight = 16'h3111;
        do_reset();
        bus_if.ptr_dout = 64'hC033_C032_C031_C030;
        for (int p = 0; p < 4; p++) pend[p] = 4;
        refresh_rdy();
        run(64);
        pk24 = {ack_at(0), ack_at(1), ack_at(2), ack_at(3), ack_at(4), ack_at(5)};
        check_eq("wrr_window1", 64'(pk24), 64'h124888);
        pk24 = {ack_at(6), ack_at(7), ack_at(8), ack_at(9), ack_at(10), ack_at(11)};
        check_eq("wrr_window2", 64'(pk24), 64'h124888);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/swc_egress_sched.md
Name: swc_egress_sched

Overview:
- Egress scheduler for the shared cell SRAM of the switch core.
- Arbitrates among the 4 output queue controllers and acknowledges the winning queue pointer.
- Sequences the 4-beat cell read from the data SRAM and steers the read data to the selected output cell FIFO.
- Decrements the multicast reference count and returns fully released pointers to the free queue.

Parameters:
- NPORT, 4, number of output queues/ports (bit layouts below fixed for 4).
- RD_LAT, 1, data SRAM read latency in cycles (addr to dout).
- MC_LAT, 1, multicast-count RAM read latency in cycles.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ptr_rdy  in  4  per-queue pointer available
- ptr_dout  in  64  queue pointers; port p at [16p+15:16p]; bit15 last, bit14 first, [9:0] cell address
- ptr_ack  out  4  one-hot, 1-cycle pop of granted queue
- o_cell_bp  in  4  per-port output FIFO backpressure
- cfg_weight  in  16  per-port WRR weight, 4 bits each (see Optional Feature)
- sram_rd_en  out  1  data SRAM read strobe
- sram_rd_addr  out  12  {cell[9:0], beat[1:0]}
- o_cell_fifo_wr  out  4  one-hot write to output FIFO, aligned to SRAM dout
- o_cell_first  out  1  aligned with beat 0 write when ptr bit14 set
- o_cell_last  out  1  aligned with beat 3 write when ptr bit15 set
- mc_addr  out  10  multicast-count RAM address
- mc_rd_data  in  4  remaining reference count
- mc_wr_en  out  1  count write-back strobe
- mc_wr_data  out  4  decremented count
- fq_wr  out  1  1-cycle pulse, free the cell
- fq_din  out  10  freed cell address
- sched_err  out  1  sticky, count read as 0

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0; credits loaded from weights; sched_err cleared.
- eligible[p] = ptr_rdy[p] & ~o_cell_bp[p] (& credit[p]!=0 with WRR).
- IDLE: if any eligible, go GRANT.
- GRANT:
  - Pick the first eligible port at or after the RR pointer, cyclic.
  - Latch its ptr_dout slice; pulse ptr_ack for that port.
  - Set RR pointer to winner+1 mod 4; go BEAT with beat=0.
  - If no port is eligible (a request dropped), return to IDLE with no ack.
- BEAT:
  - sram_rd_en=1 and sram_rd_addr={cell,beat} each cycle; beat increments 0..3.
  - beat 0: mc_addr=cell.
  - beat MC_LAT: mc_wr_en=1 and mc_wr_data=mc_rd_data-1.
  - If mc_rd_data==1 at that cycle: fq_wr=1, fq_din=cell.
  - If mc_rd_data==0: write 0, no fq_wr, set sched_err.
  - After beat 3: go GRANT if any eligible, else IDLE. Back-to-back cells therefore cost 5 cycles each.
- Output alignment:
  - o_cell_fifo_wr, o_cell_first and o_cell_last are sram_rd_en/beat qualifiers delayed exactly RD_LAT cycles.
  - Exactly 4 one-hot writes per cell.
- Backpressure is sampled only at GRANT. A cell in progress always completes.
- ptr_rdy is sampled only in GRANT.
- Reset asserted mid-cell aborts immediately. Delay pipeline flushed; no further fifo_wr/fq_wr.
- Beat counter is 2 bits and wraps 3 to 0 only on cell end.
- Arithmetic:
  - mc_wr_data is 4-bit subtraction.
  - Underflow is prevented by the 0 case above.

Optional Feature:
- Macro SWC_SCHED_WRR_EN.
- Defined:
  - Per-port 4-bit credit counter; weight 0 is treated as 1.
  - Each grant decrements the granted port's credit.
  - If no port passes ready & ~bp & credit while some port passes ready & ~bp, all credits reload from cfg_weight in that cycle and arbitration uses the reloaded credits.
  - cfg_weight is sampled only at reload.
- Undefined: plain round-robin; cfg_weight is ignored and credit logic is absent.

Decomposition:
- Package swc_pkg:
  - State enum (IDLE, GRANT, BEAT).
  - Pointer field positions (LAST_BIT=15, FIRST_BIT=14, ADDR_MSB=9).
  - BEATS_PER_CELL=4.
- Sub-module swc_rr_arb: combinational 4-way rotating-priority picker with registered pointer. Inputs req[3:0], adv; outputs grant one-hot.

Test Plan:
- Single unicast cell:
  - Stimulus: ptr_rdy=0001, ptr=0xC005, mc_rd_data=1.
  - Response: ptr_ack=0001 for one cycle; addrs 0x014–0x017; o_cell_fifo_wr=0001 ×4 starting RD_LAT later; first on beat 0, last on beat 3; fq_wr with fq_din=5 once.
- Round-robin fairness:
  - Stimulus: all 4 ready continuously, no bp.
  - Response: grant order 0,1,2,3,0; 5 cycles per cell.
- Multicast count:
  - Stimulus: cell 0x2A with mc_rd_data=3.
  - Response: mc_wr_data=2, no fq_wr. Then with mc_rd_data=1: mc_wr_data=0 and fq_wr.
- Backpressure:
  - Stimulus: o_cell_bp=0010 raised mid-cell of port 1; ports 1 and 2 ready.
  - Response: port 1 cell completes its 4 writes; next grant goes to port 2; port 1 is not granted until bp drops.
- WRR (SWC_SCHED_WRR_EN):
  - Stimulus: weights {1,1,1,3} (port3=3), all ready.
  - Response: per reload window, port 3 gets 3 grants and the others 1 each.
- Error/reset:
  - mc_rd_data=0 → sched_err=1, no fq_wr.
  - rst asserted at beat 2 → next cycle all outputs 0 and no further fifo_wr.
